// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width, channel encoding and scheduler states.
package audio_pkg;

  localparam int AUDIO_DATA_WIDTH = 24;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START_L,
    WAIT_L,
    START_R,
    WAIT_R,
    OUTPUT
  } sched_state_t;

endpackage

// File: rtl/engine_watchdog.sv
// Per-job watchdog: counts wait cycles and flags the cycle in which the
// engine has used up its whole allowance.
module engine_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count completed wait cycles; the counter parks on its last value
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (count_en && count != LAST) begin
      count <= count + CW'(1);
    end
  end

  // The wait cycle numbered TIMEOUT_CYCLES (first wait cycle is 1) expires
  assign expired = count_en && (count == LAST);

endmodule

// File: rtl/fir_channel_scheduler.sv
// Shares one mono FIR engine between left and right: captures a stereo pair,
// runs left then right through the engine and emits one stereo strobe.
module fir_channel_scheduler
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH     = AUDIO_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_bypass,
  input  logic                  i_clear_stats,
  input  logic                  i_data_valid,
  input  logic [DATA_WIDTH-1:0] i_data_left,
  input  logic [DATA_WIDTH-1:0] i_data_right,
  output logic                  o_eng_start,
  output logic                  o_eng_channel,
  output logic [DATA_WIDTH-1:0] o_eng_data,
  input  logic                  i_eng_done,
  input  logic [DATA_WIDTH-1:0] i_eng_data,
  output logic                  o_data_valid,
  output logic [DATA_WIDTH-1:0] o_data_left,
  output logic [DATA_WIDTH-1:0] o_data_right,
  output logic                  o_busy,
  output logic [15:0]           o_overrun_count,
  output logic                  o_timeout
);

  sched_state_t state, next_state;

  logic [DATA_WIDTH-1:0] cap_left, cap_right;
  logic [DATA_WIDTH-1:0] res_left, res_right;
  logic [DATA_WIDTH-1:0] res_left_next, res_right_next;
  logic capture, overrun, timeout_hit, load_out, in_wait, expired;

  assign in_wait      = (state == WAIT_L) || (state == WAIT_R);
  assign o_eng_start  = (state == START_L) || (state == START_R);
  assign o_data_valid = (state == OUTPUT);
  assign o_busy       = (state != IDLE);

  engine_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (i_clock),
    .reset_n (i_reset_n),
    .clear   (o_eng_start),
    .count_en(in_wait),
    .expired (expired)
  );

  // Next-state, result selection and capture/overrun decisions
  always_comb begin
    next_state     = state;
    capture        = 1'b0;
    overrun        = 1'b0;
    timeout_hit    = 1'b0;
    load_out       = 1'b0;
    res_left_next  = res_left;
    res_right_next = res_right;
    case (state)
      IDLE, OUTPUT: begin
        next_state = IDLE;
        if (i_data_valid) begin
          capture    = 1'b1;
          next_state = i_bypass ? OUTPUT : START_L;
        end
      end
      START_L: begin
        overrun    = i_data_valid;
        next_state = WAIT_L;
      end
      WAIT_L: begin
        overrun = i_data_valid;
        if (i_eng_done) begin
          res_left_next = i_eng_data;
          next_state    = START_R;
        end else if (expired) begin
          res_left_next = cap_left;
          timeout_hit   = 1'b1;
          next_state    = START_R;
        end
      end
      START_R: begin
        overrun    = i_data_valid;
        next_state = WAIT_R;
      end
      WAIT_R: begin
        overrun = i_data_valid;
        if (i_eng_done) begin
          res_right_next = i_eng_data;
          load_out       = 1'b1;
          next_state     = OUTPUT;
        end else if (expired) begin
          res_right_next = cap_right;
          timeout_hit    = 1'b1;
          load_out       = 1'b1;
          next_state     = OUTPUT;
        end
      end
      default: next_state = IDLE;
    endcase
    if (capture && i_bypass) begin
      res_left_next  = i_data_left;
      res_right_next = i_data_right;
      load_out       = 1'b1;
    end
  end

  // Scheduler state register
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture, result, engine-request and output sample registers
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      cap_left      <= '0;
      cap_right     <= '0;
      res_left      <= '0;
      res_right     <= '0;
      o_data_left   <= '0;
      o_data_right  <= '0;
      o_eng_channel <= CH_LEFT;
      o_eng_data    <= '0;
    end else begin
      if (capture) begin
        cap_left  <= i_data_left;
        cap_right <= i_data_right;
      end
      res_left  <= res_left_next;
      res_right <= res_right_next;
      if (load_out) begin
        o_data_left  <= res_left_next;
        o_data_right <= res_right_next;
      end
      if (next_state == START_L) begin
        o_eng_channel <= CH_LEFT;
        o_eng_data    <= i_data_left;
      end else if (next_state == START_R) begin
        o_eng_channel <= CH_RIGHT;
        o_eng_data    <= cap_right;
      end
    end
  end

  // Saturating overrun count and sticky timeout flag; same-cycle events beat a clear
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      o_overrun_count <= '0;
      o_timeout       <= 1'b0;
    end else if (i_clear_stats) begin
      o_overrun_count <= overrun ? 16'd1 : 16'd0;
      o_timeout       <= timeout_hit;
    end else begin
      if (overrun && o_overrun_count != 16'hFFFF) begin
        o_overrun_count <= o_overrun_count + 16'd1;
      end
      if (timeout_hit) begin
        o_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fir_channel_scheduler.md
# fir_channel_scheduler

Time-multiplexes one single-channel processing engine (fixed-point FIR) between the left and right audio channels. Sits between the I2S deserializer output and the serializer input. Captures each stereo sample pair, issues left then right jobs to the engine over a start/done handshake, and reassembles the results into one stereo output strobe. Provides bypass, a per-job watchdog, and overrun accounting.

## Interface
- DATA_WIDTH, 24, sample width in bits (two's complement)
- TIMEOUT_CYCLES, 1023, maximum wait for `i_eng_done` per job before substitution
- i_clock  in  1  system clock
- i_reset_n  in  1  synchronous, active-low reset
- i_bypass  in  1  when 1, captured samples skip the engine
- i_clear_stats  in  1  clears `o_overrun_count` and `o_timeout`
- i_data_valid  in  1  one-cycle strobe from the deserializer
- i_data_left / i_data_right  in  DATA_WIDTH  input samples, valid with the strobe
- o_eng_start  out  1  one-cycle job request to the engine
- o_eng_channel  out  1  0 = left, 1 = right; held from start until the job ends
- o_eng_data  out  DATA_WIDTH  job input sample; held from start until the job ends
- i_eng_done  in  1  engine result strobe
- i_eng_data  in  DATA_WIDTH  engine result, valid with `i_eng_done`
- o_data_valid  out  1  one-cycle stereo output strobe to the serializer
- o_data_left / o_data_right  out  DATA_WIDTH  output samples; held until the next strobe
- o_busy  out  1  high in any state other than IDLE
- o_overrun_count  out  16  saturating count of dropped input strobes
- o_timeout  out  1  sticky flag: at least one job was substituted

## Operation
- States: IDLE, START_L, WAIT_L, START_R, WAIT_R, OUTPUT.
- **IDLE**
  - On `i_data_valid`: capture L/R and the current `i_bypass`.
  - If bypass is 0, go to START_L. If bypass is 1, copy the captured samples to the result registers and go to OUTPUT.
- **START_L / START_R**
  - `o_eng_start` is 1 for exactly this cycle.
  - Channel and data are driven; the watchdog is cleared.
  - Next state is WAIT_L / WAIT_R.
- **WAIT_x**
  - `i_eng_done` stores `i_eng_data` into the x result register.
  - WAIT_L then goes to START_R; WAIT_R then goes to OUTPUT.
  - If the watchdog reaches TIMEOUT_CYCLES first: the captured input sample of x is stored instead, `o_timeout` is set, and the FSM advances the same way.
  - If done and timeout occur in the same cycle, done wins.
- **OUTPUT**
  - `o_data_valid` = 1 and the output registers are updated.
  - Next state is IDLE.
  - If `i_data_valid` is also high this cycle, the new pair is captured and the FSM goes directly to START_L (or stays in OUTPUT when bypass is 1).
- **Overrun:** `i_data_valid` in START_x or WAIT_x drops the new pair. The job in flight is unaffected and `o_overrun_count` increments, saturating at 0xFFFF.
- **Clear:** `i_clear_stats` zeroes the count and the flag. If a clear coincides with an overrun, the count becomes 1. If a clear coincides with a timeout, the flag becomes 1.
- `i_eng_done` outside WAIT_x is ignored.
- The engine is assumed to accept a start in any cycle. A late done from a timed-out job is ignored unless the FSM is already in the next WAIT state; engine designers must honour TIMEOUT_CYCLES.
- **Arithmetic:** none on samples; data is passed bit-exact. Watchdog width is clog2(TIMEOUT_CYCLES+1).

## Timing
- **Reset:** FSM goes to IDLE. All outputs, result registers, count and flag are 0.
- **Reset mid-job:** the job is aborted with no `o_data_valid`, and a subsequent `i_eng_done` is ignored.
- **Latency** (strobe sampled in cycle t, engine done in the cycle after start):
  - START_L in t+1, done in t+2, START_R in t+3, done in t+4, `o_data_valid` in t+5.
  - Each extra engine cycle per job adds one cycle.
- **Bypass:** `o_data_valid` in t+1.
- **Timeout:** substitution occurs in WAIT cycle number TIMEOUT_CYCLES, counted from 1 at the first WAIT cycle.
- **Throughput:** one pair per 5 cycles minimum, far above the audio frame rate.

## Structure
- Shared package `audio_pkg`: `AUDIO_DATA_WIDTH`, the channel encoding constants `CH_LEFT`/`CH_RIGHT`, and the scheduler state enum.
- One sub-module, `engine_watchdog`: clear input, count-enable, and an expiry pulse at TIMEOUT_CYCLES.

## Test plan
- **Normal path:** engine echoes the input + 1 after 3 cycles. Input L=0x000010, R=0xFFFFF0 → output L=0x000011, R=0xFFFFF1; `o_data_valid` 9 cycles after the strobe; channel sequence 0 then 1.
- **Bypass:** `i_bypass`=1, L=0x7FFFFF, R=0x800000 → identical samples at t+1; no `o_eng_start`.
- **Overrun:** a second strobe in WAIT_L → first pair completes correctly; `o_overrun_count`=1. 70000 overruns → count holds at 0xFFFF. Clear coinciding with an overrun → count 1.
- **Timeout:** TIMEOUT_CYCLES=8, engine never answers on left only → left output equals the captured input at WAIT cycle 8; right is processed normally; `o_timeout`=1. Done and expiry in the same cycle → engine data used.
- **Back-to-back:** a strobe in the OUTPUT cycle → accepted; START_L on the next cycle; no overrun count.
- **Reset mid-job:** reset during WAIT_R, then a done pulse → no `o_data_valid`, all outputs 0; the next strobe is processed normally.
